seg_scan_decoder: RTL and testbench

Receive-side counterpart to the team's hex-to-seven-segment encoder. Monitors a multiplexed, active-low seven-segment bus (segments, decimal point and per-digit anodes). Each pattern that stays stable is decoded back to a 4-bit hex value per digit. Used on loop-back and board-test paths to read back the displayed digits, flag illegal patterns, and stream digit changes to a consumer over a valid/ready handshake.

---
 rtl/seg_scan_decoder.sv | 206 ++++++++++++++++++++
 tb/tb_seg_scan_decoder.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_decoder.sv
// ============================================================================
// seg_scan_decoder
// Reads a multiplexed active-low seven-segment bus back into hex nibbles,
// flags illegal patterns and streams digit changes over valid/ready.
// Revision: 1.0
// ============================================================================
`default_nettype none

module seg_scan_decoder #(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [6:0]            seg_n,
    input  logic                  dp_n,
    input  logic [DIGITS-1:0]     an_n,
    input  logic                  clr_err,
    output logic [4*DIGITS-1:0]   digits,
    output logic [DIGITS-1:0]     digit_valid,
    output logic [DIGITS-1:0]     dp,
    output logic                  upd_valid,
    input  logic                  upd_ready,
    output logic [2:0]            upd_idx,
    output logic [3:0]            upd_nibble,
    output logic                  bad_pat,
    output logic                  overrun
);

    localparam logic [7:0]        C_STABLE    = 8'(STABLE_CYCLES);
    localparam logic [7:0]        C_STABLE_M1 = 8'(STABLE_CYCLES - 1);
    localparam logic [DIGITS-1:0] C_ONE       = DIGITS'(1);

    // Returns {legal, blank, nibble}
    function automatic logic [5:0] decode(input logic [6:0] seg);
        logic [5:0] r;
        r = 6'b000000;
        case (seg)
            7'h01: r = {2'b10, 4'h0};
            7'h4F: r = {2'b10, 4'h1};
            7'h12: r = {2'b10, 4'h2};
            7'h06: r = {2'b10, 4'h3};
            7'h4C: r = {2'b10, 4'h4};
            7'h24: r = {2'b10, 4'h5};
            7'h20: r = {2'b10, 4'h6};
            7'h0F: r = {2'b10, 4'h7};
            7'h00: r = {2'b10, 4'h8};
            7'h04: r = {2'b10, 4'h9};
            7'h08: r = {2'b10, 4'hA};
            7'h60: r = {2'b10, 4'hB};
            7'h31: r = {2'b10, 4'hC};
            7'h42: r = {2'b10, 4'hD};
            7'h30: r = {2'b10, 4'hE};
            7'h38: r = {2'b10, 4'hF};
            7'h7F: r = {2'b01, 4'h0};
            default: r = 6'b000000;
        endcase
        return r;
    endfunction

    logic [6:0]          s_seg_q, s_seg_d, p_seg_q, p_seg_d;
    logic [DIGITS-1:0]   s_an_q, s_an_d, p_an_q, p_an_d;
    logic                s_dp_q, s_dp_d, p_dp_q, p_dp_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [4*DIGITS-1:0] digits_q, digits_d;
    logic [DIGITS-1:0]   digit_valid_q, digit_valid_d;
    logic [DIGITS-1:0]   dp_q, dp_d;
    logic                upd_valid_q, upd_valid_d;
    logic [2:0]          upd_idx_q, upd_idx_d;
    logic [3:0]          upd_nibble_q, upd_nibble_d;
    logic                bad_pat_q, bad_pat_d;
    logic                overrun_q, overrun_d;

    logic                w_same, w_one, w_cap, w_upd;
    logic [DIGITS-1:0]   w_sel;
    logic [2:0]          w_idx;
    logic [3:0]          w_old_nib;
    logic                w_old_vld;
    logic [5:0]          w_dec;

    always_comb begin
        s_seg_d       = seg_n;
        s_an_d        = an_n;
        s_dp_d        = dp_n;
        p_seg_d       = s_seg_q;
        p_an_d        = s_an_q;
        p_dp_d        = s_dp_q;
        cnt_d         = cnt_q;
        digits_d      = digits_q;
        digit_valid_d = digit_valid_q;
        dp_d          = dp_q;
        upd_valid_d   = upd_valid_q;
        upd_idx_d     = upd_idx_q;
        upd_nibble_d  = upd_nibble_q;
        bad_pat_d     = bad_pat_q;
        overrun_d     = overrun_q;
        w_idx         = 3'd0;
        w_old_nib     = 4'h0;
        w_old_vld     = 1'b0;

        w_same = (s_seg_q == p_seg_q) && (s_an_q == p_an_q) && (s_dp_q == p_dp_q);
        w_sel  = ~s_an_q;
        w_one  = (w_sel != '0) && ((w_sel & (w_sel - C_ONE)) == '0);
        w_cap  = w_same && w_one && (cnt_q == C_STABLE_M1);
        w_dec  = decode(s_seg_q);

        if (!w_same || !w_one) begin
            cnt_d = 8'd0;
        end else if (cnt_q != C_STABLE) begin
            cnt_d = cnt_q + 8'd1;
        end

        for (int i = 0; i < DIGITS; i++) begin
            if (w_sel[i]) begin
                w_idx     = 3'(i);
                w_old_nib = digits_q[4*i +: 4];
                w_old_vld = digit_valid_q[i];
            end
        end

        if (w_cap) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (w_sel[i]) begin
                    digit_valid_d[i] = w_dec[5];
                    if (w_dec[5]) begin
                        digits_d[4*i +: 4] = w_dec[3:0];
                    end
                    if (w_dec[5] || w_dec[4]) begin
                        dp_d[i] = ~s_dp_q;
                    end
                end
            end
        end

        w_upd = w_cap && w_dec[5] && (!w_old_vld || (w_old_nib != w_dec[3:0]));

        if (upd_valid_q && upd_ready) begin
            upd_valid_d = 1'b0;
        end
        if (w_upd) begin
            upd_valid_d  = 1'b1;
            upd_idx_d    = w_idx;
            upd_nibble_d = w_dec[3:0];
        end

        // Clear first so a coincident set wins
        if (clr_err) begin
            bad_pat_d = 1'b0;
            overrun_d = 1'b0;
        end
        if (w_cap && !w_dec[5] && !w_dec[4]) begin
            bad_pat_d = 1'b1;
        end
        if (w_upd && upd_valid_q && !upd_ready) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_seg_q       <= 7'h7F;
            p_seg_q       <= 7'h7F;
            s_an_q        <= '1;
            p_an_q        <= '1;
            s_dp_q        <= 1'b1;
            p_dp_q        <= 1'b1;
            cnt_q         <= 8'd0;
            digits_q      <= '0;
            digit_valid_q <= '0;
            dp_q          <= '0;
            upd_valid_q   <= 1'b0;
            upd_idx_q     <= 3'd0;
            upd_nibble_q  <= 4'h0;
            bad_pat_q     <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            s_seg_q       <= s_seg_d;
            p_seg_q       <= p_seg_d;
            s_an_q        <= s_an_d;
            p_an_q        <= p_an_d;
            s_dp_q        <= s_dp_d;
            p_dp_q        <= p_dp_d;
            cnt_q         <= cnt_d;
            digits_q      <= digits_d;
            digit_valid_q <= digit_valid_d;
            dp_q          <= dp_d;
            upd_valid_q   <= upd_valid_d;
            upd_idx_q     <= upd_idx_d;
            upd_nibble_q  <= upd_nibble_d;
            bad_pat_q     <= bad_pat_d;
            overrun_q     <= overrun_d;
        end
    end

    assign digits      = digits_q;
    assign digit_valid = digit_valid_q;
    assign dp          = dp_q;
    assign upd_valid   = upd_valid_q;
    assign upd_idx     = upd_idx_q;
    assign upd_nibble  = upd_nibble_q;
    assign bad_pat     = bad_pat_q;
    assign overrun     = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_decoder.sv
// ============================================================================
// tb_seg_scan_decoder
// Directed-vector self-checking bench for seg_scan_decoder (4 digits, 16 cycles).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_seg_scan_decoder;

    localparam int DIGITS        = 4;
    localparam int STABLE_CYCLES = 16;

    logic                clk;
    logic                rst;
    logic [6:0]          seg_n;
    logic                dp_n;
    logic [DIGITS-1:0]   an_n;
    logic                clr_err;
    logic [4*DIGITS-1:0] digits;
    logic [DIGITS-1:0]   digit_valid;
    logic [DIGITS-1:0]   dp;
    logic                upd_valid;
    logic                upd_ready;
    logic [2:0]          upd_idx;
    logic [3:0]          upd_nibble;
    logic                bad_pat;
    logic                overrun;

    int n_chk  = 0;
    int n_pass = 0;

    logic [6:0] c_codes [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                                 7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

    seg_scan_decoder #(
        .DIGITS        (DIGITS),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .seg_n       (seg_n),
        .dp_n        (dp_n),
        .an_n        (an_n),
        .clr_err     (clr_err),
        .digits      (digits),
        .digit_valid (digit_valid),
        .dp          (dp),
        .upd_valid   (upd_valid),
        .upd_ready   (upd_ready),
        .upd_idx     (upd_idx),
        .upd_nibble  (upd_nibble),
        .bad_pat     (bad_pat),
        .overrun     (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Leaves the bench 1 time unit after a rising edge
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] an, input logic [6:0] seg, input logic dpn);
        an_n  = an;
        seg_n = seg;
        dp_n  = dpn;
    endtask

    task automatic accept();
        upd_ready = 1'b1;
        tick(1);
        upd_ready = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        seg_n     = 7'h7F;
        dp_n      = 1'b1;
        an_n      = 4'hF;
        clr_err   = 1'b0;
        upd_ready = 1'b0;
        tick(3);
        chk("reset_outputs", {digits, digit_valid, dp, upd_valid, upd_idx, upd_nibble, bad_pat, overrun}, 64'd0);
        rst = 1'b0;
        tick(2);

        // Single digit with exact latency
        drive(4'b1110, 7'h12, 1'b1);
        tick(17);
        chk("single_not_yet", digit_valid, 4'b0000);
        tick(1);
        chk("single_digits", digits[3:0], 4'h2);
        chk("single_valid", digit_valid, 4'b0001);
        chk("single_upd", {upd_valid, upd_idx, upd_nibble}, {1'b1, 3'd0, 4'h2});
        tick(10);
        chk("single_no_repeat", {upd_valid, overrun}, {1'b1, 1'b0});
        accept();
        chk("single_accept", upd_valid, 1'b0);

        // Interrupted run on digit 1
        drive(4'b1101, 7'h12, 1'b1);
        tick(10);
        drive(4'b1101, 7'h06, 1'b1);
        tick(17);
        chk("stab_no_early", {digit_valid[1], upd_valid}, 2'b00);
        tick(1);
        chk("stab_capture", {digits[7:4], digit_valid[1], upd_valid, upd_idx, upd_nibble}, {4'h3, 1'b1, 1'b1, 3'd1, 4'h3});
        accept();

        // Illegal then blank on digit 1 showing 5
        drive(4'b1101, 7'h24, 1'b1);
        tick(18);
        chk("ill_pre5", digits[7:4], 4'h5);
        accept();
        drive(4'b1101, 7'h7E, 1'b1);
        tick(18);
        chk("ill_flags", {bad_pat, digit_valid[1], digits[7:4], upd_valid}, {1'b1, 1'b0, 4'h5, 1'b0});
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        chk("ill_clr", bad_pat, 1'b0);
        drive(4'b1101, 7'h24, 1'b1);
        tick(18);
        chk("ill_revalid", {digit_valid[1], upd_valid, upd_nibble}, {1'b1, 1'b1, 4'h5});
        accept();
        drive(4'b1101, 7'h7F, 1'b1);
        tick(18);
        chk("blank_flags", {digit_valid[1], bad_pat, digits[7:4], upd_valid}, {1'b0, 1'b0, 4'h5, 1'b0});

        // Two captures without ready
        drive(4'b1011, 7'h0F, 1'b1);
        tick(18);
        chk("ovr_first", {upd_valid, upd_idx, upd_nibble, overrun}, {1'b1, 3'd2, 4'h7, 1'b0});
        drive(4'b0111, 7'h08, 1'b1);
        tick(18);
        chk("ovr_second", {overrun, upd_valid, upd_idx, upd_nibble}, {1'b1, 1'b1, 3'd3, 4'hA});
        accept();
        chk("ovr_accept", upd_valid, 1'b0);
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        chk("ovr_clr", overrun, 1'b0);

        // Full code table on digit 3, decimal point only with A
        upd_ready = 1'b1;
        for (int v = 0; v < 16; v++) begin
            drive(4'b0111, c_codes[v], (v == 10) ? 1'b0 : 1'b1);
            tick(18);
            chk($sformatf("scan_%0h", v), {digits[15:12], digit_valid[3], dp[3], upd_nibble},
                {4'(v), 1'b1, (v == 10) ? 1'b1 : 1'b0, 4'(v)});
        end
        tick(1);
        upd_ready = 1'b0;
        chk("scan_end", {upd_valid, overrun, bad_pat}, 3'b000);
        chk("scan_state", {digits, digit_valid, dp}, {16'hF752, 4'b1101, 4'b0000});

        // Two anodes, then none: no capture, no error
        drive(4'b1100, 7'h7E, 1'b1);
        tick(20);
        drive(4'b1111, 7'h7E, 1'b1);
        tick(20);
        chk("multi_an", {digits, digit_valid, bad_pat, upd_valid}, {16'hF752, 4'b1101, 1'b0, 1'b0});

        // Asynchronous reset in the middle of a run
        drive(4'b1110, 7'h4F, 1'b1);
        tick(8);
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset", {digits, digit_valid, dp, upd_valid, upd_idx, upd_nibble, bad_pat, overrun}, 64'd0);
        tick(1);
        rst = 1'b0;
        tick(12);
        chk("reset_discard", digit_valid, 4'b0000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
